tmds_encoder_hdmi: RTL and testbench
====================================

Name: tmds_encoder_hdmi

Overview:
Multi-channel TMDS encoder for the HDMI output path, replacing the single-channel DVI-only encoder. Each lane encodes 8-bit video with DC balancing, 2-bit control symbols, 4-bit TERC4 data-island symbols and the HDMI video/data guard bands, all selected by a shared mode input. It has a fixed-latency pipeline with clock enable and sits between the video timing/packet mux and the serialisers.

Parameters:
CHANNELS, 3, number of TMDS lanes; lane k uses guard-band role (k mod 3).
REG_OUT, 1, 1 adds an output register stage; 0 omits it.

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  synchronous reset, active-high
i_ce  in  1  clock enable; when low all pipeline state holds
i_mode  in  3  period type: 0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 DATA, 4 DATA_GB, 5-7 treated as CTRL
i_data  in  8*CHANNELS  video pixel per lane, lane k at [8k+7:8k]
i_ctrl  in  2*CHANNELS  control bits per lane (lane 0 = {vsync,hsync})
i_aux  in  4*CHANNELS  TERC4 nibble per lane
o_tmds  out  10*CHANNELS  encoded symbol per lane, bit 0 transmitted first
o_bias  out  5*CHANNELS  signed running disparity per lane (debug)

Behaviour:
- Reset (i_rst high at a clock edge, ignoring i_ce): every o_tmds lane = 10'b1101010100 (CTRL 00), every pipeline stage and bias = 0. Reset mid-stream discards in-flight symbols.
- Latency: input to o_tmds = 2 + REG_OUT cycles, counting only cycles with i_ce high. Mode, data and ctrl travel together through the pipeline. No bubbles. One symbol per enabled cycle.
- Stage 1 per lane: count ones in i_data (n, 4 bits). Use XNOR when n>4, or when n==4 and d[0]==0. Build qm[8:0] as a chained XOR/XNOR, with qm[8]=~use_xnor. Register qm, n1 = popcount(qm[7:0]), and mode/ctrl/aux.
- Stage 2 VIDEO: balance = n1-n0 (signed 5-bit, range -8..+8).
  - If bias==0 or balance==0: out = {~qm8, qm8, qm8 ? qm[7:0] : ~qm[7:0]}. bias += qm8 ? balance : -balance.
  - Else if sign(bias)==sign(balance): out = {1, qm8, ~qm[7:0]}. bias = bias + 2*qm8 - balance.
  - Else: out = {0, qm8, qm[7:0]}. bias = bias - 2*(~qm8) + balance.
  - Bias is signed 5-bit. It must stay within -16..+15 by algorithm; a bench assertion is required.
- Stage 2 non-video: bias is cleared to 0 on every symbol.
  - CTRL: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - DATA: TERC4(i_aux lane).
  - VIDEO_GB: role 0 and role 2 → 1011001100; role 1 → 0100110011.
  - DATA_GB: role 0 → TERC4({2'b11, i_ctrl[1:0]}); roles 1 and 2 → 0100110011.
- TERC4 table, values 0-15: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000111, 1010001110, 1001110001, 0101100011, 1011000011.
- Mode switches take effect on the symbol boundary. A switch out of VIDEO and back restarts with bias 0.
- The i_ce low then high sequence is lossless: outputs resume exactly as if i_ce had stayed high.

Decomposition:
- Package tmds_pkg holds:
  - mode enum (tmds_mode_t, 3 bits)
  - CTRL_SYM[4], TERC4_SYM[16], VGB_SYM0/1, DGB_SYM constants
  - RST_SYM = CTRL_SYM[0]
- Sub-module tmds_lane: one-lane pipeline with a LANE_ROLE parameter, instantiated CHANNELS times by a generate loop.

Test Plan:
- Reset, then mode CTRL, ctrl 00 on all lanes → o_tmds lanes = 0x354 after 3 cycles; ctrl 11 → 0x2AB; o_bias = 0.
- VIDEO, lane 0 data 0x00 two cycles from bias 0 → 0x100 with bias -8, then 0x3FF with bias +2.
- DATA, aux 0..15 swept → each lane matches the TERC4 table in order, e.g. 0→0x29C, 15→0x2C3.
- VIDEO_GB → lane0 0x2CC, lane1 0x133, lane2 0x2CC. DATA_GB with vsync=1, hsync=0 → lane0 TERC4(14)=0x163, lanes 1 and 2 0x133.
- Random video for 10k cycles with random i_ce gaps, compared against a reference model → exact symbol match. Decoder round-trip returns the data, and |bias| ≤ 10 always.
- Assert i_rst mid-VIDEO with bias nonzero → next edge all lanes 0x354, o_bias 0. First video symbol after release is encoded from bias 0.

Source files
------------

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS mode encoding, symbol tables and popcount helper shared by the encoder lanes.
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL     = 3'd0,
        MODE_VIDEO    = 3'd1,
        MODE_VIDEO_GB = 3'd2,
        MODE_DATA     = 3'd3,
        MODE_DATA_GB  = 3'd4
    } tmds_mode_t;

    localparam logic [9:0] CTRL_SYM [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_SYM [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [9:0] VGB_SYM0 = 10'b1011001100;
    localparam logic [9:0] VGB_SYM1 = 10'b0100110011;
    localparam logic [9:0] DGB_SYM  = 10'b0100110011;
    localparam logic [9:0] RST_SYM  = CTRL_SYM[0];

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane.sv
// rtl/tmds_lane.sv - One TMDS lane: transition-minimising stage, DC-balance/period stage, optional output register.
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int LANE_ROLE = 0,
    parameter int REG_OUT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [2:0] mode,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    input  logic [3:0] aux,
    output logic [9:0] tmds,
    output logic [4:0] bias
);

    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] qm;
    tmds_mode_t mode_in;

    logic [8:0] s1_qm;
    logic [3:0] s1_n1;
    tmds_mode_t s1_mode;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_aux;

    logic [4:0] balance;
    logic       q8;
    logic [9:0] sym;
    logic [4:0] nbias;
    logic [9:0] s2_sym;
    logic [4:0] s2_bias;

    always_comb begin
        logic acc;
        n        = popcount8(data);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !data[0]);
        acc      = data[0];
        qm       = '0;
        qm[0]    = acc;
        for (int i = 1; i < 8; i++) begin
            acc   = use_xnor ? ~(acc ^ data[i]) : (acc ^ data[i]);
            qm[i] = acc;
        end
        qm[8]   = ~use_xnor;
        // Reserved codes 5..7 behave as control periods.
        mode_in = (mode > 3'd4) ? MODE_CTRL : tmds_mode_t'(mode);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_qm   <= '0;
            s1_n1   <= '0;
            s1_mode <= MODE_CTRL;
            s1_ctrl <= '0;
            s1_aux  <= '0;
        end else if (ce) begin
            s1_qm   <= qm;
            s1_n1   <= popcount8(qm[7:0]);
            s1_mode <= mode_in;
            s1_ctrl <= ctrl;
            s1_aux  <= aux;
        end
    end

    always_comb begin
        balance = {s1_n1, 1'b0} - 5'd8;
        q8      = s1_qm[8];
        sym     = RST_SYM;
        nbias   = 5'd0;
        case (s1_mode)
            MODE_VIDEO: begin
                if ((s2_bias == 5'd0) || (balance == 5'd0)) begin
                    sym   = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
                    nbias = q8 ? (s2_bias + balance) : (s2_bias - balance);
                end else if (s2_bias[4] == balance[4]) begin
                    sym   = {1'b1, q8, ~s1_qm[7:0]};
                    nbias = s2_bias + {3'b000, q8, 1'b0} - balance;
                end else begin
                    sym   = {1'b0, q8, s1_qm[7:0]};
                    nbias = s2_bias - {3'b000, ~q8, 1'b0} + balance;
                end
            end
            MODE_VIDEO_GB: sym = (LANE_ROLE == 1) ? VGB_SYM1 : VGB_SYM0;
            MODE_DATA:     sym = TERC4_SYM[s1_aux];
            MODE_DATA_GB:  sym = (LANE_ROLE == 0) ? TERC4_SYM[{2'b11, s1_ctrl}] : DGB_SYM;
            default:       sym = CTRL_SYM[s1_ctrl];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sym  <= RST_SYM;
            s2_bias <= 5'd0;
        end else if (ce) begin
            s2_sym  <= sym;
            s2_bias <= nbias;
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [9:0] out_sym;
        logic [4:0] out_bias;
        always_ff @(posedge clk) begin
            if (rst) begin
                out_sym  <= RST_SYM;
                out_bias <= 5'd0;
            end else if (ce) begin
                out_sym  <= s2_sym;
                out_bias <= s2_bias;
            end
        end
        assign tmds = out_sym;
        assign bias = out_bias;
    end else begin : g_comb_out
        assign tmds = s2_sym;
        assign bias = s2_bias;
    end

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// rtl/tmds_encoder_hdmi.sv - Multi-lane HDMI TMDS encoder; lane k takes guard-band role k mod 3.
module tmds_encoder_hdmi
    import tmds_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int REG_OUT  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ce,
    input  logic [2:0]              i_mode,
    input  logic [8*CHANNELS-1:0]   i_data,
    input  logic [2*CHANNELS-1:0]   i_ctrl,
    input  logic [4*CHANNELS-1:0]   i_aux,
    output logic [10*CHANNELS-1:0]  o_tmds,
    output logic [5*CHANNELS-1:0]   o_bias
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        tmds_lane #(
            .LANE_ROLE (g % 3),
            .REG_OUT   (REG_OUT)
        ) u_lane (
            .clk  (i_clk),
            .rst  (i_rst),
            .ce   (i_ce),
            .mode (i_mode),
            .data (i_data[8*g +: 8]),
            .ctrl (i_ctrl[2*g +: 2]),
            .aux  (i_aux[4*g +: 4]),
            .tmds (o_tmds[10*g +: 10]),
            .bias (o_bias[5*g +: 5])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_hdmi.sv
// tb/tb_tmds_encoder_hdmi.sv - Self-checking bench for tmds_encoder_hdmi against a behavioural symbol model.
module tb_tmds_encoder_hdmi;

    localparam int CH = 3;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          ce   = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [23:0]   data = '0;
    logic [5:0]    ctrl = '0;
    logic [11:0]   aux  = '0;
    logic [29:0]   tmds;
    logic [14:0]   bias;

    int checks = 0;
    int passes = 0;
    bit started = 1'b0;

    typedef struct packed {
        logic [2:0][9:0] sym;
        logic [2:0][4:0] bias;
        logic [2:0]      mode;
        logic [2:0][7:0] data;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    int   mbias[CH];

    logic [9:0] ctrl_tab [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] terc_tab [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                                  10'h2CC, 10'h139, 10'h19C, 10'h2C7, 10'h28E, 10'h271, 10'h163, 10'h2C3};

    tmds_encoder_hdmi #(.CHANNELS(CH), .REG_OUT(1)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_ce   (ce),
        .i_mode (mode),
        .i_data (data),
        .i_ctrl (ctrl),
        .i_aux  (aux),
        .o_tmds (tmds),
        .o_bias (bias)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (started && !rst) begin
            for (int k = 0; k < CH; k++) begin
                assert ($signed(bias[5*k +: 5]) >= -10 && $signed(bias[5*k +: 5]) <= 10)
                    else $error("FAIL bias_bound lane %0d got %0d need |bias|<=10", k, $signed(bias[5*k +: 5]));
            end
        end
    end

    function automatic ent_t rst_ent();
        ent_t e;
        e = '0;
        for (int k = 0; k < CH; k++) e.sym[k] = 10'h354;
        return e;
    endfunction

    // Symbol for one period from the HDMI rules; running disparity kept as plain integers.
    task automatic encode(input logic [2:0] md_raw, input logic [23:0] d, input logic [5:0] c,
                          input logic [11:0] a, output ent_t e);
        int md;
        e  = '0;
        md = (md_raw > 3'd4) ? 0 : int'(md_raw);
        e.mode = 3'(md);
        for (int k = 0; k < CH; k++) begin
            logic [7:0] dv;
            logic [8:0] qv;
            logic [1:0] cv;
            int n, n1, bal, role;
            bit xn;
            dv   = d[8*k +: 8];
            cv   = c[2*k +: 2];
            role = k % 3;
            e.data[k] = dv;
            if (md == 1) begin
                n  = $countones(dv);
                xn = (n > 4) || (n == 4 && !dv[0]);
                qv[0] = dv[0];
                for (int i = 1; i < 8; i++) qv[i] = xn ? ~(qv[i-1] ^ dv[i]) : (qv[i-1] ^ dv[i]);
                qv[8] = !xn;
                n1  = $countones(qv[7:0]);
                bal = n1 - (8 - n1);
                if (mbias[k] == 0 || bal == 0) begin
                    e.sym[k] = {~qv[8], qv[8], qv[8] ? qv[7:0] : ~qv[7:0]};
                    mbias[k] = mbias[k] + (qv[8] ? bal : -bal);
                end else if ((mbias[k] > 0) == (bal > 0)) begin
                    e.sym[k] = {1'b1, qv[8], ~qv[7:0]};
                    mbias[k] = mbias[k] + 2 * int'(qv[8]) - bal;
                end else begin
                    e.sym[k] = {1'b0, qv[8], qv[7:0]};
                    mbias[k] = mbias[k] - 2 * int'(!qv[8]) + bal;
                end
            end else begin
                mbias[k] = 0;
                case (md)
                    2:       e.sym[k] = (role == 1) ? 10'h133 : 10'h2CC;
                    3:       e.sym[k] = terc_tab[a[4*k +: 4]];
                    4:       e.sym[k] = (role == 0) ? terc_tab[{2'b11, cv}] : 10'h133;
                    default: e.sym[k] = ctrl_tab[cv];
                endcase
            end
            e.bias[k] = 5'(mbias[k]);
        end
    endtask

    task automatic step(input bit en, input logic [2:0] md, input logic [23:0] d,
                        input logic [5:0] c, input logic [11:0] a);
        ent_t e;
        ce = en; mode = md; data = d; ctrl = c; aux = a;
        @(posedge clk);
        if (en) begin
            encode(md, d, c, a, e);
            q.push_back(e);
            cur = q.pop_front();
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b0;
        @(posedge clk);
        for (int k = 0; k < CH; k++) mbias[k] = 0;
        q.delete();
        q.push_back(rst_ent());
        q.push_back(rst_ent());
        cur = rst_ent();
        #1;
        rst = 1'b0;
        started = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (tmds[10*k +: 10] !== 10'h354) $display("FAIL reset_sym lane %0d got %h need 354", k, tmds[10*k +: 10]);
            else passes++;
            checks++;
            if (bias[5*k +: 5] !== 5'd0) $display("FAIL reset_bias lane %0d got %0d need 0", k, bias[5*k +: 5]);
            else passes++;
        end
    endtask

    task automatic test_ctrl();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 24'hA5A5A5, 6'b000000, 12'h0);
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (tmds[10*k +: 10] !== 10'h354) $display("FAIL ctrl00 lane %0d got %h need 354", k, tmds[10*k +: 10]);
            else passes++;
        end
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 24'h0, 6'b111111, 12'h0);
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (tmds[10*k +: 10] !== 10'h2AB) $display("FAIL ctrl11 lane %0d got %h need 2ab", k, tmds[10*k +: 10]);
            else passes++;
            checks++;
            if (bias[5*k +: 5] !== 5'd0) $display("FAIL ctrl_bias lane %0d got %0d need 0", k, bias[5*k +: 5]);
            else passes++;
        end
    endtask

    task automatic test_video_seq();
        do_reset();
        step(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
        step(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
        step(1'b1, 3'd0, 24'h0, 6'h0, 12'h0);
        checks++;
        if (tmds[9:0] !== 10'h100 || bias[4:0] !== 5'b11000)
            $display("FAIL video_first got %h/%0d need 100/-8", tmds[9:0], $signed(bias[4:0]));
        else passes++;
        step(1'b1, 3'd0, 24'h0, 6'h0, 12'h0);
        checks++;
        if (tmds[9:0] !== 10'h3FF || bias[4:0] !== 5'd2)
            $display("FAIL video_second got %h/%0d need 3ff/2", tmds[9:0], $signed(bias[4:0]));
        else passes++;
        step(1'b1, 3'd0, 24'h0, 6'h0, 12'h0);
        checks++;
        if (bias[4:0] !== 5'd0) $display("FAIL video_exit_bias got %0d need 0", $signed(bias[4:0]));
        else passes++;
    endtask

    task automatic test_data_terc4();
        for (int i = 0; i < 18; i++) begin
            logic [3:0] v;
            v = 4'(i);
            if (i < 16) step(1'b1, 3'd3, 24'(i * 37), 6'h0, {v, v, v});
            else        step(1'b1, 3'd0, 24'h0, 6'h0, 12'h0);
            if (i >= 2) begin
                for (int k = 0; k < CH; k++) begin
                    checks++;
                    if (tmds[10*k +: 10] !== terc_tab[i-2])
                        $display("FAIL terc4_%0d lane %0d got %h need %h", i - 2, k, tmds[10*k +: 10], terc_tab[i-2]);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_guard_bands();
        logic [9:0] vgb_need [3] = '{10'h2CC, 10'h133, 10'h2CC};
        logic [9:0] dgb_need [3] = '{10'h163, 10'h133, 10'h133};
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 24'h123456, 6'h0, 12'h0);
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (tmds[10*k +: 10] !== vgb_need[k]) $display("FAIL video_gb lane %0d got %h need %h", k, tmds[10*k +: 10], vgb_need[k]);
            else passes++;
        end
        for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 24'h0, 6'b011110, 12'hFFF);
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (tmds[10*k +: 10] !== dgb_need[k]) $display("FAIL data_gb lane %0d got %h need %h", k, tmds[10*k +: 10], dgb_need[k]);
            else passes++;
        end
    endtask

    task automatic test_random_video(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bit en;
            logic [2:0] md;
            en = ($urandom_range(0, 3) != 0);
            md = ($urandom_range(0, 9) < 7) ? 3'd1 : 3'($urandom_range(0, 7));
            step(en, md, 24'($urandom), 6'($urandom), 12'($urandom));
            for (int k = 0; k < CH; k++) begin
                logic [9:0] s;
                logic [7:0] qd, dd;
                s = tmds[10*k +: 10];
                checks++;
                if (s !== cur.sym[k] || bias[5*k +: 5] !== cur.bias[k])
                    $display("FAIL rand_sym c%0d lane %0d got %h/%0d need %h/%0d", c, k, s,
                             $signed(bias[5*k +: 5]), cur.sym[k], $signed(cur.bias[k]));
                else passes++;
                if (cur.mode == 3'd1) begin
                    qd = s[9] ? ~s[7:0] : s[7:0];
                    dd[0] = qd[0];
                    for (int i = 1; i < 8; i++) dd[i] = s[8] ? (qd[i] ^ qd[i-1]) : ~(qd[i] ^ qd[i-1]);
                    checks++;
                    if (dd !== cur.data[k]) $display("FAIL roundtrip c%0d lane %0d got %h need %h", c, k, dd, cur.data[k]);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int tries;
        tries = 0;
        while (cur.bias[0] == 5'd0 && tries < 100) begin
            step(1'b1, 3'd1, 24'($urandom), 6'h0, 12'h0);
            tries++;
        end
        checks++;
        if (bias[4:0] === 5'd0) $display("FAIL midstream_setup got bias %0d need nonzero", $signed(bias[4:0]));
        else passes++;
        data = 24'($urandom);
        mode = 3'd1;
        do_reset();
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (tmds[10*k +: 10] !== 10'h354 || bias[5*k +: 5] !== 5'd0)
                $display("FAIL midstream_rst lane %0d got %h/%0d need 354/0", k, tmds[10*k +: 10], $signed(bias[5*k +: 5]));
            else passes++;
        end
        step(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
        step(1'b0, 3'd1, 24'hFFFFFF, 6'h0, 12'h0);
        step(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
        step(1'b1, 3'd1, 24'h0, 6'h0, 12'h0);
        checks++;
        if (tmds[9:0] !== 10'h100 || bias[4:0] !== 5'b11000)
            $display("FAIL post_rst_video got %h/%0d need 100/-8", tmds[9:0], $signed(bias[4:0]));
        else passes++;
        test_random_video(40);
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_video_seq();
        test_data_terc4();
        test_guard_bands();
        test_random_video(10000);
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
